// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over a valid/ready load
// handshake, shifts it out one bit per clock with s_valid framing, then pulses done.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             r_sout,  w_sout_nxt;
  logic             r_svld,  w_svld_nxt;
  logic             r_done,  w_done_nxt;

  // The bit to transmit next sits at the "head" end selected by MSB_FIRST.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_svld  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
      r_svld  <= w_svld_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_sout_nxt  = r_sout;
    w_svld_nxt  = r_svld;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sout_nxt = 1'b0;
        w_svld_nxt = 1'b0;
        if (load_valid) begin
          // First bit goes straight to s_out; the rest wait in the shift register.
          w_sout_nxt  = head_bit(p_in);
          w_shift_nxt = advance(p_in);
          w_cnt_nxt   = LAST_IDX;
          w_svld_nxt  = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_sout_nxt  = head_bit(r_shift);
          w_shift_nxt = advance(r_shift);
          w_cnt_nxt   = r_cnt - CW'(1);
        end else begin
          w_sout_nxt  = 1'b0;
          w_svld_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign load_ready = (r_state == IDLE);
  assign s_out      = r_sout;
  assign s_valid    = r_svld;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances,
// back-to-back handshake, mid-frame clear, and a 4-stage SISO downstream.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] p_m, p_l;
  logic       lv_m, lv_l;
  logic       rdy_m, sout_m, sval_m, done_m;
  logic       rdy_l, sout_l, sval_l, done_l;
  logic [3:0] r_siso;
  int         errs   = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clear(clear), .p_in(p_m), .load_valid(lv_m),
    .load_ready(rdy_m), .s_out(sout_m), .s_valid(sval_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clear(clear), .p_in(p_l), .load_valid(lv_l),
    .load_ready(rdy_l), .s_out(sout_l), .s_valid(sval_l), .done(done_l)
  );

  // Downstream 4-stage SISO chain fed by the MSB-first serializer.
  always @(posedge clk or negedge clear) begin
    if (!clear) r_siso <= 4'b0;
    else        r_siso <= {r_siso[2:0], sout_m};
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m(input string tag, input logic es, input logic ev,
                         input logic ed, input logic er);
    check({tag, ".s_out"},      sout_m, es);
    check({tag, ".s_valid"},    sval_m, ev);
    check({tag, ".done"},       done_m, ed);
    check({tag, ".load_ready"}, rdy_m,  er);
  endtask

  logic [0:7] t2_s, t2_v, t2_d, t2_r, t2_q;
  logic [0:5] t3_s, t3_v, t3_d;
  logic [0:9] t4_s, t4_v, t4_d;
  logic [0:5] t5_s, t5_v, t5_d;

  initial begin
    clear = 1'b0;
    p_m   = 4'bxxxx;
    p_l   = 4'b0000;
    lv_m  = 1'b0;
    lv_l  = 1'b0;

    // Test 1: reset state with p_in unknown, before any clock edge.
    #2;
    check_m("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_l.s_out", sout_l, 1'b0);
    check("rst_l.load_ready", rdy_l, 1'b1);
    tick();
    tick();
    check_m("rst_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    p_m   = 4'b0000;
    tick();
    tick();
    check_m("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 2 + 6: MSB-first 1011, and the SISO tap 4 clocks behind.
    t2_s = 8'b1011_0000;
    t2_v = 8'b1111_0000;
    t2_d = 8'b0000_1000;
    t2_r = 8'b0000_1111;
    t2_q = 8'b0000_1011;
    p_m  = 4'b1011;
    lv_m = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) lv_m = 1'b0;
      check_m($sformatf("msb_E%0d", k), t2_s[k], t2_v[k], t2_d[k], t2_r[k]);
      check($sformatf("siso_E%0d", k), r_siso[3], t2_q[k]);
    end

    // Test 3: LSB-first 1011 -> 1,1,0,1.
    t3_s = 6'b1101_00;
    t3_v = 6'b1111_00;
    t3_d = 6'b0000_10;
    p_l  = 4'b1011;
    lv_l = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) lv_l = 1'b0;
      check($sformatf("lsb_E%0d.s_out", k), sout_l, t3_s[k]);
      check($sformatf("lsb_E%0d.s_valid", k), sval_l, t3_v[k]);
      check($sformatf("lsb_E%0d.done", k), done_l, t3_d[k]);
    end

    // Test 4: load_valid held, p_in changed mid-frame; next word taken in done cycle.
    t4_s = 10'b1011_0_0110_0;
    t4_v = 10'b1111_0_1111_0;
    t4_d = 10'b0000_1_0000_1;
    p_m  = 4'b1011;
    lv_m = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) p_m = 4'b0110;
      if (k == 5) lv_m = 1'b0;
      check_m($sformatf("b2b_E%0d", k), t4_s[k], t4_v[k], t4_d[k], t4_d[k]);
    end
    tick();

    // Test 5: clear pulsed after E1 aborts the frame with no done.
    p_m  = 4'b1011;
    lv_m = 1'b1;
    tick();
    lv_m = 1'b0;
    check_m("abort_E0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_m("abort_E1", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 clear = 1'b0;
    #1;
    check_m("abort_now", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check_m("abort_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    tick();
    tick();
    check_m("abort_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    t5_s = 6'b1111_00;
    t5_v = 6'b1111_00;
    t5_d = 6'b0000_10;
    p_m  = 4'b1111;
    lv_m = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) lv_m = 1'b0;
      check_m($sformatf("post_E%0d", k), t5_s[k], t5_v[k], t5_d[k], ~t5_v[k]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
